axi_ethernet_v3_01_a_cdc_xfer_arbiter: RTL and testbench
========================================================

Name: axi_ethernet_v3_01_a_cdc_xfer_arbiter

Overview:
- Source-domain controller for one shared toggle-handshake CDC channel.
- Several requesters in the same clock domain each want to move a multi-bit word (config write, statistics snapshot request) to another clock domain. They share that one channel.
- The block round-robin arbitrates between them and holds the winner's word stable on xfer_data. It toggles xfer_req, then waits for the returning ack toggle through a two-flop synchroniser.
- Optional timeout with sticky error.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, width of the transferred word.
- TIMEOUT, 1024, cycles to wait for ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  NUM_REQ*DATA_WIDTH  requester words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant pulse; data accepted this cycle.
- req_done  out  NUM_REQ  one-hot completion pulse for the granted requester.
- xfer_req  out  1  toggle to destination domain, registered.
- xfer_data  out  DATA_WIDTH  held word, registered, stable while busy.
- ack_toggle  in  1  raw toggle from destination domain, asynchronous to clk.
- busy  out  1  transfer in flight.
- timeout_err  out  1  sticky; set on timeout, cleared only by reset.
- err_id  out  clog2(NUM_REQ)  requester id of the most recent timeout.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - outputs: xfer_req=0, xfer_data=0, req_done=0, busy=0, timeout_err=0, err_id=0.
  - internal: rr pointer=0, state=IDLE, timeout counter=0, synchroniser flops=0.
- req_ready is combinational from state, req_valid and the rr pointer; all other outputs are registered.
- States: IDLE, WAIT_ACK, DONE.
- IDLE:
  - If any req_valid, grant the first set bit searching from the rr pointer upward with wrap-around. Drive req_ready[g]=1 this cycle.
  - At the clock edge: xfer_data<=req_data[g], gnt_id<=g, xfer_req<=~xfer_req, busy<=1, counter<=0, state<=WAIT_ACK.
  - If no req_valid, hold.
- WAIT_ACK:
  - ack_s is ack_toggle after two flops, and is used only in this state.
  - If ack_s==xfer_req, go to DONE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1, abort: timeout_err<=1, err_id<=gnt_id, go to DONE.
  - Else counter++.
- DONE (one cycle):
  - req_done[gnt_id]=1, busy<=0, rr pointer<=(gnt_id+1) mod NUM_REQ, state<=IDLE.
  - The done pulse also fires on abort; requesters read timeout_err.
- Latency:
  - req_valid sampled in cycle 0 gives req_ready in cycle 0 and the xfer_req toggle in cycle 1.
  - An ack_toggle edge at cycle k appears on ack_s at cycle k+2 and gives req_done at cycle k+3.
  - Next grant is at the earliest the cycle after DONE.
  - Minimum back-to-back period is 3 cycles plus the ack round trip.
- Requester holding req_valid high after req_done is re-arbitrated normally; the rr pointer guarantees the others are served first.
- req_valid dropping while not granted is ignored (no commitment). req_valid changes after grant do not affect the transfer in flight.
- After an abort, a late ack toggle can make ack_s mismatch xfer_req. In that case the next transfer completes early on ack_s equality. This is accepted; software treats timeout_err as fatal until reset.
- Reset asserted mid-transfer: immediate return to reset values; the destination side must also be reset.
- xfer_data is never changed while busy=1.

Decomposition:
- Shared Verilog header (axi_ethernet_v3_01_a_cdc_defs.vh):
  - state encodings IDLE=2'd0, WAIT_ACK=2'd1, DONE=2'd2;
  - clog2 constant function.
- Sub-modules:
  - Instantiate the existing axi_ethernet_v3_01_a_sync_block (INITIALISE=2'b00) for ack_toggle; no new synchroniser RTL.
  - Round-robin priority pick as axi_ethernet_v3_01_a_rr_pick (purely combinational: req, pointer -> one-hot grant, id).

Test Plan:
- Single request: req_valid=4'b0010, req_data[1]=32'hDEADBEEF; ack_toggle follows xfer_req after 5 cycles. Expect req_ready=0010 at cycle 0, xfer_req=1 and xfer_data=DEADBEEF from cycle 1, req_done=0010 exactly 3 cycles after the ack edge, busy=0 after.
- Fairness: all four req_valid held high with an auto-ack model. Expect grant order 0,1,2,3,0 and xfer_req alternating 1,0,1,0,1.
- Timeout: TIMEOUT=16, req 2, ack never toggles. Expect req_done=0100 at cycle 17, timeout_err=1 (sticky), err_id=2.
- Data stability: change req_data[0] every cycle during WAIT_ACK. Expect xfer_data to stay at the value sampled at grant.
- Mid-transfer reset: drop resetn in WAIT_ACK. Expect all outputs at reset values immediately (asynchronously), and a clean transfer after release with xfer_req 0->1.
- TIMEOUT=0 with ack delayed 5000 cycles. Expect no timeout_err and normal completion.

Source files
------------

// File: rtl/axi_ethernet_v3_01_a_cdc_xfer_arbiter_pkg.sv
// Shared types and helpers for the CDC transfer arbiter.
package axi_ethernet_v3_01_a_cdc_xfer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } arb_state_e;

    // Ceiling log2, used for id and counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_ethernet_v3_01_a_cdc_xfer_arbiter_if.sv
// Requester-side and CDC-channel signals of the transfer arbiter.
// slave: the arbiter; master: the requesters plus the destination side.
interface axi_ethernet_v3_01_a_cdc_xfer_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic                          xfer_req;
    logic [DATA_WIDTH-1:0]         xfer_data;
    logic                          ack_toggle;

    modport slave (
        input  req_valid, req_data, ack_toggle,
        output req_ready, req_done, xfer_req, xfer_data
    );

    modport master (
        output req_valid, req_data, ack_toggle,
        input  req_ready, req_done, xfer_req, xfer_data
    );
endinterface

// File: rtl/axi_ethernet_v3_01_a_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping around.
module axi_ethernet_v3_01_a_rr_pick
    import axi_ethernet_v3_01_a_cdc_xfer_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);
    int              idx;
    logic [ID_W-1:0] idx_l;

    // wrap-around priority search starting at ptr
    always_comb begin
        gnt   = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        idx_l = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr) + k) % NUM_REQ;
            idx_l = ID_W'(idx);
            if (!any && req[idx_l]) begin
                gnt[idx_l] = 1'b1;
                id         = idx_l;
                any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_ethernet_v3_01_a_sync_block.sv
// Two-flop synchroniser for a single level/toggle signal entering clk.
module axi_ethernet_v3_01_a_sync_block #(
    parameter logic [1:0] INITIALISE = 2'b00
) (
    input  logic clk,
    input  logic resetn,
    input  logic data_in,
    output logic data_out
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the raw input through two stages
    always_comb begin
        sync_d = {sync_q[0], data_in};
    end

    // synchroniser stages
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= INITIALISE;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign data_out = sync_q[1];
endmodule

// File: rtl/axi_ethernet_v3_01_a_cdc_xfer_arbiter.sv
// Source-domain controller sharing one toggle-handshake CDC channel
// between several requesters, with optional ack timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | channel free; grant next requester round-robin
// WAIT_ACK | xfer_req toggled, word held; waiting for ack_s to match
// DONE     | one cycle; req_done pulse, advance rr pointer
module axi_ethernet_v3_01_a_cdc_xfer_arbiter
    import axi_ethernet_v3_01_a_cdc_xfer_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 1024,
    localparam int ID_W       = clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    axi_ethernet_v3_01_a_cdc_xfer_arbiter_if.slave bus,
    output logic                                  busy,
    output logic                                  timeout_err,
    output logic [ID_W-1:0]                       err_id
);
    // Counter only needs to reach TIMEOUT-1; it is free-running (unused)
    // when the timeout is disabled.
    localparam int              CNT_W    = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic                  xfer_req_q, xfer_req_d;
    logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [ID_W-1:0]       err_id_q, err_id_d;
    logic [NUM_REQ-1:0]    req_done_q, req_done_d;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  ack_s;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    axi_ethernet_v3_01_a_sync_block #(
        .INITIALISE (2'b00)
    ) u_ack_sync (
        .clk      (clk),
        .resetn   (resetn),
        .data_in  (bus.ack_toggle),
        .data_out (ack_s)
    );

    axi_ethernet_v3_01_a_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    // next-state and output decode
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_id_d      = gnt_id_q;
        xfer_req_d    = xfer_req_q;
        xfer_data_d   = xfer_data_q;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        err_id_d      = err_id_q;
        req_done_d    = '0;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready   = pick_gnt;
                    xfer_data_d = req_word[pick_id];
                    gnt_id_d    = pick_id;
                    xfer_req_d  = ~xfer_req_q;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == xfer_req_q) begin
                    req_done_d[gnt_id_q] = 1'b1;
                    state_d              = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // abort still completes the requester; it must check timeout_err
                    timeout_err_d        = 1'b1;
                    err_id_d             = gnt_id_q;
                    req_done_d[gnt_id_q] = 1'b1;
                    state_d              = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d   = 1'b0;
                rr_ptr_d = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_id_q      <= '0;
            xfer_req_q    <= 1'b0;
            xfer_data_q   <= '0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
            req_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_id_q      <= gnt_id_d;
            xfer_req_q    <= xfer_req_d;
            xfer_data_q   <= xfer_data_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
            req_done_q    <= req_done_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.req_done  = req_done_q;
    assign bus.xfer_req  = xfer_req_q;
    assign bus.xfer_data = xfer_data_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign err_id        = err_id_q;
endmodule

// File: tb/tb_axi_ethernet_v3_01_a_cdc_xfer_arbiter.sv
// Directed bench: dut_a (TIMEOUT=16) for arbitration, latency, timeout and
// reset; dut_b (TIMEOUT=0) for a very slow ack.
module tb_axi_ethernet_v3_01_a_cdc_xfer_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    axi_ethernet_v3_01_a_cdc_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifa ();
    axi_ethernet_v3_01_a_cdc_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifb ();

    logic       busy_a, terr_a, busy_b, terr_b;
    logic [1:0] eid_a, eid_b;

    axi_ethernet_v3_01_a_cdc_xfer_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(16)
    ) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa),
        .busy(busy_a), .timeout_err(terr_a), .err_id(eid_a)
    );

    axi_ethernet_v3_01_a_cdc_xfer_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb),
        .busy(busy_b), .timeout_err(terr_b), .err_id(eid_b)
    );

    typedef struct {
        logic [3:0] valid;
        int         exp_id;
        logic       exp_xreq;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] words [4];
    int          tests_run    = 0;
    int          tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_words();
        ifa.req_data = {words[3], words[2], words[1], words[0]};
        ifb.req_data = {words[3], words[2], words[1], words[0]};
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn         = 1'b0;
        ifa.req_valid  = '0;
        ifb.req_valid  = '0;
        ifa.ack_toggle = 1'b0;
        ifb.ack_toggle = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One transfer on dut_a: grant, hold, ack after ack_delay cycles, done.
    task automatic run_xfer(input string tag, input logic [3:0] valid, input int exp_id,
                            input logic exp_xreq, input int ack_delay, input bit scramble);
        logic [3:0]  gnt;
        logic [31:0] exp_data;
        int          lat;
        gnt      = 4'b0001 << exp_id;
        exp_data = words[exp_id];
        @(negedge clk);
        ifa.req_valid = valid;
        #1;
        chk({tag, ".ready"}, ifa.req_ready, gnt);
        @(negedge clk);
        ifa.req_valid = '0;
        chk({tag, ".xfer_req"}, ifa.xfer_req, exp_xreq);
        chk({tag, ".xfer_data"}, ifa.xfer_data, exp_data);
        chk({tag, ".busy"}, busy_a, 1'b1);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            if (scramble) begin
                ifa.req_data[31:0] = $urandom;
                #1;
                chk($sformatf("%s.hold%0d", tag, i), ifa.xfer_data, exp_data);
            end
        end
        ifa.ack_toggle = exp_xreq;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ifa.req_done != 0) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".done_lat"}, lat, 3);
        chk({tag, ".done"}, ifa.req_done, gnt);
        @(negedge clk);
        chk({tag, ".busy_after"}, busy_a, 1'b0);
        chk({tag, ".done_pulse"}, ifa.req_done, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic early;

        words[0] = 32'h0123_4567;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'hCAFE_F00D;
        words[3] = 32'h8000_0001;

        vecs[0]  = '{4'b1111, 0, 1'b1};
        vecs[1]  = '{4'b1111, 1, 1'b0};
        vecs[2]  = '{4'b1111, 2, 1'b1};
        vecs[3]  = '{4'b1111, 3, 1'b0};
        vecs[4]  = '{4'b1111, 0, 1'b1};
        vecs[5]  = '{4'b1000, 3, 1'b0};
        vecs[6]  = '{4'b0110, 1, 1'b1};
        vecs[7]  = '{4'b0011, 0, 1'b0};
        vecs[8]  = '{4'b1001, 3, 1'b1};
        vecs[9]  = '{4'b0100, 2, 1'b0};
        vecs[10] = '{4'b0101, 0, 1'b1};

        resetn         = 1'b0;
        ifa.req_valid  = '0;
        ifb.req_valid  = '0;
        ifa.ack_toggle = 1'b0;
        ifb.ack_toggle = 1'b0;
        load_words();
        repeat (3) @(negedge clk);
        #1;
        chk("rst.xfer_req", ifa.xfer_req, 1'b0);
        chk("rst.xfer_data", ifa.xfer_data, 32'h0);
        chk("rst.req_done", ifa.req_done, 4'b0000);
        chk("rst.busy", busy_a, 1'b0);
        chk("rst.timeout_err", terr_a, 1'b0);
        chk("rst.err_id", eid_a, 2'd0);
        chk("rst.b_busy", busy_b, 1'b0);
        resetn = 1'b1;

        run_xfer("single", 4'b0010, 1, 1'b1, 5, 1'b0);
        run_xfer("stable", 4'b0001, 0, 1'b0, 6, 1'b1);
        load_words();

        do_reset();
        for (int v = 0; v < 11; v++) begin
            run_xfer($sformatf("vec%0d", v), vecs[v].valid, vecs[v].exp_id, vecs[v].exp_xreq, 0, 1'b0);
        end

        // timeout: ack stays at 1 while xfer_req goes to 0
        @(negedge clk);
        ifa.req_valid = 4'b0100;
        #1;
        chk("to.ready", ifa.req_ready, 4'b0100);
        chk("to.err_before", terr_a, 1'b0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            ifa.req_valid = '0;
            if (ifa.req_done != 0) begin
                lat = i;
                break;
            end
        end
        chk("to.done_lat", lat, 17);
        chk("to.done", ifa.req_done, 4'b0100);
        chk("to.timeout_err", terr_a, 1'b1);
        chk("to.err_id", eid_a, 2'd2);
        @(negedge clk);
        ifa.ack_toggle = 1'b0;
        repeat (3) @(negedge clk);
        chk("to.sticky", terr_a, 1'b1);
        chk("to.sticky_id", eid_a, 2'd2);
        chk("to.busy_after", busy_a, 1'b0);

        // reset while waiting for ack
        @(negedge clk);
        ifa.req_valid = 4'b1000;
        #1;
        chk("mr.ready", ifa.req_ready, 4'b1000);
        @(negedge clk);
        ifa.req_valid = '0;
        chk("mr.xfer_req", ifa.xfer_req, 1'b1);
        chk("mr.busy", busy_a, 1'b1);
        chk("mr.xfer_data", ifa.xfer_data, words[3]);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mr.rst_xfer_req", ifa.xfer_req, 1'b0);
        chk("mr.rst_xfer_data", ifa.xfer_data, 32'h0);
        chk("mr.rst_busy", busy_a, 1'b0);
        chk("mr.rst_timeout_err", terr_a, 1'b0);
        chk("mr.rst_err_id", eid_a, 2'd0);
        chk("mr.rst_req_done", ifa.req_done, 4'b0000);
        ifa.ack_toggle = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run_xfer("post_rst", 4'b0100, 2, 1'b1, 0, 1'b0);

        // dut_b: timeout disabled, ack arrives 5000 cycles late
        @(negedge clk);
        ifb.req_valid = 4'b0010;
        #1;
        chk("b.ready", ifb.req_ready, 4'b0010);
        @(negedge clk);
        ifb.req_valid = '0;
        chk("b.xfer_req", ifb.xfer_req, 1'b1);
        chk("b.xfer_data", ifb.xfer_data, words[1]);
        early = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (ifb.req_done != 0 || terr_b) early = 1'b1;
        end
        chk("b.no_early_done", early, 1'b0);
        chk("b.busy_wait", busy_b, 1'b1);
        ifb.ack_toggle = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ifb.req_done != 0) begin
                lat = i;
                break;
            end
        end
        chk("b.done_lat", lat, 3);
        chk("b.done", ifb.req_done, 4'b0010);
        chk("b.timeout_err", terr_b, 1'b0);
        @(negedge clk);
        chk("b.busy_after", busy_b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
